// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - RV32I load/store unit shared types, funct3 codes and byte-enable helper
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_t;

    // Stores share the low funct3 codes with loads, so one decode covers both.
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: lsu_byte_en = 4'b0001 << addr_lo;
            F3_LH, F3_LHU: lsu_byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:       lsu_byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - word-addressed data memory bus between the LSU (master) and memory (slave)
interface lsu_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/halfword lane of a read word and extends it
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  data = {24'h0, lane_b};
            F3_LH:   data = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  data = {16'h0, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: one outstanding access, request/grant/rvalid memory bus
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned halfword/word accesses instead of masking low bits.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    lsu_if.master       mem
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        legal;
    logic [31:0] store_lanes;
    logic [31:0] load_data;

    always_comb begin
        case (req_funct3)
            F3_LB, F3_LH, F3_LW: legal = 1'b1;
            F3_LBU, F3_LHU:      legal = !req_we;
            default:             legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3 == F3_LH || req_funct3 == F3_LHU) && req_addr[0])
            legal = 1'b0;
        if (req_funct3 == F3_LW && req_addr[1:0] != 2'b00)
            legal = 1'b0;
`endif
    end

    always_comb begin
        case (req_funct3)
            F3_SB:   store_lanes = {4{req_wdata[7:0]}};
            F3_SH:   store_lanes = {2{req_wdata[15:0]}};
            default: store_lanes = req_wdata;
        endcase
    end

    lsu_load_align u_load_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (mem.mem_rdata),
        .data    (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= 32'h0;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            addr_lo_q     <= 2'b00;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= 4'b0000;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        if (legal) begin
                            state         <= REQ;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= req_we;
                            mem.mem_be    <= lsu_byte_en(req_funct3, req_addr[1:0]);
                            mem.mem_addr  <= {req_addr[31:2], 2'b00};
                            mem.mem_wdata <= store_lanes;
                        end else begin
                            // Rejected accesses never touch the bus.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        mem.mem_be  <= 4'b0000;
                        if (we_q) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed table-driven bench for lsu with a reactive grant/rvalid memory stub
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    lsu_if mem_bus ();

    lsu dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        err;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int gnt_dly,
                       input logic err, input logic [3:0] be, input logic [31:0] mwdata,
                       input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gnt_dly = gnt_dly; v.err = err; v.be = be; v.mwdata = mwdata; v.exp_rdata = exp_rdata;
        vecs.push_back(v);
    endtask

    // Presents one access after a clock edge and plays memory until rsp_valid.
    task automatic run(input int idx, input vec_t v);
        int  lat;
        int  reqc;
        int  exp_lat;
        bit  granted;
        bit  rv_done;
        chk($sformatf("v%0d ready_idle", idx), {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; reqc = 0; granted = 0; rv_done = 0;
        chk($sformatf("v%0d ready_busy", idx), {31'h0, req_ready}, 32'h0);
        forever begin
            if (mem_bus.mem_gnt) begin granted = 1; mem_bus.mem_gnt = 1'b0; end
            mem_bus.mem_rvalid = 1'b0;
            if (rsp_valid) break;
            if (lat > 60) begin
                chk($sformatf("v%0d timeout", idx), 32'h1, 32'h0);
                break;
            end
            if (mem_bus.mem_req) begin
                reqc++;
                chk($sformatf("v%0d mem_addr", idx), mem_bus.mem_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d mem_be", idx), {28'h0, mem_bus.mem_be}, {28'h0, v.be});
                chk($sformatf("v%0d mem_we", idx), {31'h0, mem_bus.mem_we}, {31'h0, v.we});
                if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_bus.mem_wdata, v.mwdata);
                if (reqc == v.gnt_dly + 1) mem_bus.mem_gnt = 1'b1;
            end else if (granted && !v.we && !rv_done) begin
                mem_bus.mem_rvalid = 1'b1;
                mem_bus.mem_rdata  = v.rdata;
                rv_done = 1;
            end
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = v.err ? 1 : (v.we ? 2 + v.gnt_dly : 3 + v.gnt_dly);
        chk($sformatf("v%0d latency", idx), lat, exp_lat);
        chk($sformatf("v%0d req_cycles", idx), reqc, v.err ? 0 : v.gnt_dly + 1);
        chk($sformatf("v%0d rsp_err", idx), {31'h0, rsp_err}, {31'h0, v.err});
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        @(posedge clk); #1;
        chk($sformatf("v%0d rsp_pulse", idx), {31'h0, rsp_valid}, 32'h0);
        chk($sformatf("v%0d ready_back", idx), {31'h0, req_ready}, 32'h1);
        chk($sformatf("v%0d rdata_hold", idx), rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;

        //   we    f3      addr          wdata         rdata        gnt err be       mwdata        exp_rdata
        add(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
        add(1'b1, 3'b000, 32'h0000_0103, 32'h000000A5, 32'h0,        0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);
        add(1'b0, 3'b000, 32'h0000_0202, 32'h0,        32'h12F45678, 3, 0, 4'b0100, 32'h0,        32'hFFFFFFF4);
        add(1'b0, 3'b100, 32'h0000_0202, 32'h0,        32'h12F45678, 3, 0, 4'b0100, 32'h0,        32'h000000F4);
`ifdef LSU_MISALIGN_TRAP_EN
        add(1'b0, 3'b001, 32'h0000_0201, 32'h0,        32'h12348765, 0, 1, 4'b0000, 32'h0,        32'h0);
`else
        add(1'b0, 3'b001, 32'h0000_0201, 32'h0,        32'h12348765, 0, 0, 4'b0011, 32'h0,        32'hFFFF8765);
`endif
        add(1'b0, 3'b101, 32'h0000_0302, 32'h0,        32'h9ABC1234, 1, 0, 4'b1100, 32'h0,        32'h00009ABC);
        add(1'b0, 3'b001, 32'h0000_0302, 32'h0,        32'h9ABC1234, 0, 0, 4'b1100, 32'h0,        32'hFFFF9ABC);
        add(1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'hCAFEF00D, 2, 0, 4'b1111, 32'h0,        32'hCAFEF00D);
        add(1'b0, 3'b011, 32'h0000_0400, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        add(1'b1, 3'b001, 32'h0000_0502, 32'h0000BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0);
        add(1'b1, 3'b100, 32'h0000_0500, 32'h11223344, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        add(1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h00008000, 0, 0, 4'b0010, 32'h0,        32'hFFFFFF80);
        add(1'b0, 3'b111, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        add(1'b1, 3'b101, 32'h0000_0500, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        add(1'b1, 3'b110, 32'h0000_0500, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        add(1'b1, 3'b010, 32'h0000_0603, 32'h01020304, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
`else
        add(1'b1, 3'b010, 32'h0000_0603, 32'h01020304, 32'h0,        0, 0, 4'b1111, 32'h01020304, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
        chk("rst mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
        chk("rst mem_be", {28'h0, mem_bus.mem_be}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) run(i, vecs[i]);

        // Stray rvalid while idle must not produce a response.
        seen = 0;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h55555555;
        repeat (3) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        mem_bus.mem_rvalid = 1'b0;
        chk("idle rvalid ignored", seen, 0);

        // Reset while waiting for read data abandons the load silently.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid mem_req", {31'h0, mem_bus.mem_req}, 32'h1);
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        chk("mid in wait", {31'h0, mem_bus.mem_req}, 32'h0);
        reset = 1'b1;
        #2;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        mem_bus.mem_rvalid = 1'b0;
        chk("abandon no rsp", seen, 0);
        chk("abandon ready", {31'h0, req_ready}, 32'h1);
        chk("abandon mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
        chk("abandon rdata", rsp_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters SHALL be: none; all widths are fixed (XLEN 32).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  execute stage presents an access.
REQ-005 req_ready  output  1  LSU can accept an access.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32I load/store width code.
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  aligned, extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  access rejected; qualified by rsp_valid.
REQ-013 mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-014 mem_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-015 mem_be  output  4  byte enables.  mem_wdata  output  32  lane-placed store data.
REQ-016 mem_gnt  input  1  request accepted.  mem_rvalid  input  1  read data valid.  mem_rdata  input  32.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; access accepted on req_valid&&req_ready, all request fields registered.
REQ-019 IDLE->REQ on accept of a legal access; IDLE->RESP with err on illegal access (no mem_req ever asserted).
REQ-020 In REQ, mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata stable until the cycle mem_gnt=1.
REQ-021 REQ+gnt: store->RESP; load->WAIT.
REQ-022 WAIT: on mem_rvalid capture extracted data, ->RESP; mem_rvalid outside WAIT SHALL be ignored.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; min latency accept->rsp_valid: store 2 cycles, load 3 cycles.
REQ-024 Illegal funct3 (011, 110, 111; store also 100, 101) SHALL always give rsp_err=1.
REQ-025 Byte enables: SB 4'b0001<<addr[1:0]; SH addr[1]?4'b1100:4'b0011; SW 4'b1111; loads the same per width.
REQ-026 mem_wdata: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-027 Loads: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]/addr[1]; LW whole word.
REQ-028 rsp_rdata SHALL hold its value until the next RESP; rsp_err cleared on every non-error RESP.

Reset
REQ-029 Reset SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_be=0.
REQ-030 Reset mid-access SHALL abandon it silently: no rsp_valid, pending gnt/rvalid ignored.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN: defined -> halfword at odd address or word with addr[1:0]!=0 is illegal (rsp_err, no memory access).
REQ-032 Undefined -> low address bits beyond natural alignment SHALL be ignored (SH/LH use addr[1] only, SW/LW ignore addr[1:0]); no misalignment error.

Structure
REQ-033 Package lsu_pkg SHALL hold funct3 constants (LB..LHU, SB..SW), lsu_state_t enum, byte-enable helper function.
REQ-034 Sub-module lsu_load_align SHALL be the combinational lane-select/extension of mem_rdata.

Verification
REQ-035 SW addr 0x100 data 0xDEADBEEF, gnt immediate -> mem_be 1111, mem_addr 0x100, rsp_valid 2 cycles after accept, rsp_err 0.
REQ-036 SB addr 0x103 data 0x000000A5 -> mem_be 1000, mem_wdata 0xA5A5A5A5.
REQ-037 LB addr 0x202, mem_rdata 0x12F45678, gnt delayed 3 cycles -> mem_req held 4 cycles, rsp_rdata 0xFFFFFFF4; LBU same -> 0x000000F4.
REQ-038 LH addr 0x201 -> with macro rsp_err=1, no mem_req; without macro mem_be 0011, rsp_rdata sign-extended low half.
REQ-039 funct3 3'b011 load -> rsp_err=1 one cycle after accept, mem_req stays 0.
REQ-040 Reset asserted in WAIT, then rvalid -> no rsp_valid, req_ready=1 after reset release.
